// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris datapath: game-phase encodings, action
// codes for the piece controller, default playfield size, shape-id range and
// the pending-action bit positions. Used by the piece controller, its action
// queue, and the display/board logic.
package tetris_pkg;

    // Game phase, exported on the controller's 4-bit state port.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SPAWN = 4'd1,
        ST_FALL  = 4'd2,
        ST_CHECK = 4'd3,
        ST_LOCK  = 4'd4,
        ST_OVER  = 4'd5
    } state_t;

    // Action behind an outstanding collision query.
    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_LEFT  = 3'd1,
        ACT_RIGHT = 3'd2,
        ACT_ROT   = 3'd3,
        ACT_GRAV  = 3'd4,
        ACT_SPAWN = 3'd5
    } action_t;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 20;

    localparam logic [2:0] SHAPE_MIN = 3'd1;
    localparam logic [2:0] SHAPE_MAX = 3'd7;
    localparam logic [4:0] SCORE_MAX = 5'd31;

    // Pending-bit positions; lower index means higher priority.
    localparam int PB_L = 0;
    localparam int PB_R = 1;
    localparam int PB_T = 2;
    localparam int PB_G = 3;
    localparam int NUM_PB = 4;

    // Shape sequence 1..7, wrapping back to 1.
    function automatic logic [2:0] next_shape(input logic [2:0] cur);
        return (cur >= SHAPE_MAX) ? SHAPE_MIN : cur + 3'd1;
    endfunction

endpackage

// File: rtl/tetris_piece_ctrl_if.sv
// Collision-query handshake between the piece controller (master) and the
// board collision checker (slave).
//   chk_req      master->slave  query valid; candidate is held while high
//   cand_x/y     master->slave  candidate position (5 bits each)
//   cand_rot     master->slave  candidate rotation (3 bits)
//   chk_ack      slave->master  one-cycle response strobe
//   chk_collide  slave->master  candidate collides; meaningful only with chk_ack
interface tetris_piece_ctrl_if;
    logic       chk_req;
    logic [4:0] cand_x;
    logic [4:0] cand_y;
    logic [2:0] cand_rot;
    logic       chk_ack;
    logic       chk_collide;

    modport master (
        output chk_req, cand_x, cand_y, cand_rot,
        input  chk_ack, chk_collide
    );

    modport slave (
        input  chk_req, cand_x, cand_y, cand_rot,
        output chk_ack, chk_collide
    );
endinterface

// File: rtl/tetris_action_queue.sv
// Pending-action store for the piece controller. One sticky bit per action
// (left, right, rotate, gravity); the highest-priority pending bit is offered
// as pick, and the bit is cleared when the controller serves it.
// Ports:
//   clk, srst    clock and synchronous active-high reset
//   enable       accept new pulses (low in IDLE/OVER)
//   pulse[3:0]   one-cycle action pulses, indexed by PB_L/PB_R/PB_T/PB_G
//   serve        controller consumes the current pick this cycle
//   clear_all    drop every pending action (end of lock)
//   pending      current pending bits
//   pick         highest-priority pending action (ACT_NONE if none)
//   any          at least one bit pending
module tetris_action_queue
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              enable,
    input  logic [NUM_PB-1:0] pulse,
    input  logic              serve,
    input  logic              clear_all,
    output logic [NUM_PB-1:0] pending,
    output action_t           pick,
    output logic              any
);

    logic [NUM_PB-1:0] pending_reg;
    logic [NUM_PB-1:0] sel;

    // One-hot priority select: a bit wins only if no lower index is pending.
    always_comb begin
        logic higher;
        sel    = '0;
        higher = 1'b0;
        for (int i = 0; i < NUM_PB; i++) begin
            sel[i] = pending_reg[i] & ~higher;
            higher = higher | pending_reg[i];
        end
    end

    always_comb begin
        pick = ACT_NONE;
        if (sel[PB_L])      pick = ACT_LEFT;
        else if (sel[PB_R]) pick = ACT_RIGHT;
        else if (sel[PB_T]) pick = ACT_ROT;
        else if (sel[PB_G]) pick = ACT_GRAV;
    end

    // A new pulse wins over a clear in the same cycle so no request is lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PB; gi++) begin : g_bit
            logic bit_set;
            logic bit_clr;
            assign bit_set = enable & pulse[gi];
            assign bit_clr = clear_all | (serve & sel[gi]);

            always_ff @(posedge clk) begin
                if (srst) begin
                    pending_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= bit_set | (pending_reg[gi] & ~bit_clr);
                end
            end
        end
    endgenerate

    assign pending = pending_reg;
    assign any     = |pending_reg;

endmodule

// File: rtl/tetris_piece_ctrl.sv
// Active-piece controller. Collects debounced move/rotate/gravity pulses,
// computes each candidate position, rejects out-of-field candidates locally
// and otherwise asks the board collision checker before committing. Runs the
// game phases IDLE/SPAWN/FALL/CHECK/LOCK/OVER, the lock timer, shape sequence
// and locked-piece score.
// Ports:
//   CLOCK_50, reset        clock, synchronous active-high reset
//   start                  leave IDLE and begin a game
//   left_final/right_final/rot_final/tick_gravity   one-cycle action pulses
//   chk                    collision-query handshake (master side)
//   state                  game phase (tetris_pkg::state_t encoding)
//   piece_x/piece_y/rot    committed piece position and rotation
//   shape_id               current shape 1..7
//   score                  locked-piece count, saturating at 31
//   move_accept            one-cycle pulse when a move is committed
//   have_action            pending action exists or a query is in flight
//   lock_phase             high during LOCK
//   collide                chk_collide captured at the last ack
module tetris_piece_ctrl
    import tetris_pkg::*;
#(
    parameter int BOARD_W     = BOARD_W_DEF,
    parameter int BOARD_H     = BOARD_H_DEF,
    parameter int SPAWN_X     = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                left_final,
    input  logic                right_final,
    input  logic                rot_final,
    input  logic                tick_gravity,
    tetris_piece_ctrl_if.master chk,
    output logic [3:0]          state,
    output logic [4:0]          piece_x,
    output logic [4:0]          piece_y,
    output logic [2:0]          rot,
    output logic [2:0]          shape_id,
    output logic [4:0]          score,
    output logic                move_accept,
    output logic                have_action,
    output logic                lock_phase,
    output logic                collide
);

    localparam int         LCW     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [5:0] X_LIM   = 6'(BOARD_W);
    localparam logic [5:0] Y_MAX   = 6'(BOARD_H - 1);
    localparam logic [4:0] SPAWN_XV = 5'(SPAWN_X);

    state_t         state_reg;
    action_t        act_reg;
    logic [4:0]     x_reg, y_reg;
    logic [2:0]     rot_reg;
    logic [2:0]     shape_reg;
    logic [4:0]     score_reg;
    logic [LCW-1:0] lock_cnt_reg;
    logic           req_reg;
    logic [4:0]     cand_x_reg, cand_y_reg;
    logic [2:0]     cand_rot_reg;
    logic           accept_reg;
    logic           collide_reg;

    // Action queue
    logic [NUM_PB-1:0] pulses;
    logic [NUM_PB-1:0] pending;
    action_t           pick;
    logic              q_any;
    logic              q_enable;
    logic              q_serve;
    logic              lock_done;

    assign pulses[PB_L] = left_final;
    assign pulses[PB_R] = right_final;
    assign pulses[PB_T] = rot_final;
    assign pulses[PB_G] = tick_gravity;

    assign q_enable  = (state_reg != ST_IDLE) && (state_reg != ST_OVER);
    assign q_serve   = (state_reg == ST_FALL) && q_any;
    assign lock_done = (state_reg == ST_LOCK) && (lock_cnt_reg == LOCK_LAST);

    tetris_action_queue u_queue (
        .clk       (CLOCK_50),
        .srst      (reset),
        .enable    (q_enable),
        .pulse     (pulses),
        .serve     (q_serve),
        .clear_all (lock_done),
        .pending   (pending),
        .pick      (pick),
        .any       (q_any)
    );

    // Candidate with one bit of headroom: x-1 from 0 wraps to 63, which the
    // single unsigned compare against BOARD_W then rejects.
    logic [5:0] cx_next, cy_next;
    logic [2:0] crot_next;
    logic       cand_reject;

    always_comb begin
        cx_next   = {1'b0, x_reg};
        cy_next   = {1'b0, y_reg};
        crot_next = rot_reg;
        case (pick)
            ACT_LEFT:  cx_next   = {1'b0, x_reg} - 6'd1;
            ACT_RIGHT: cx_next   = {1'b0, x_reg} + 6'd1;
            ACT_ROT:   crot_next = {1'b0, rot_reg[1:0] + 2'd1};
            ACT_GRAV:  cy_next   = {1'b0, y_reg} + 6'd1;
            default:   ;
        endcase
        cand_reject = (cx_next >= X_LIM) || (cy_next > Y_MAX);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            act_reg      <= ACT_NONE;
            x_reg        <= SPAWN_XV;
            y_reg        <= '0;
            rot_reg      <= '0;
            shape_reg    <= SHAPE_MIN;
            score_reg    <= '0;
            lock_cnt_reg <= '0;
            req_reg      <= 1'b0;
            cand_x_reg   <= '0;
            cand_y_reg   <= '0;
            cand_rot_reg <= '0;
            accept_reg   <= 1'b0;
            collide_reg  <= 1'b0;
        end else begin
            accept_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_SPAWN;
                        x_reg     <= SPAWN_XV;
                        y_reg     <= '0;
                        rot_reg   <= '0;
                    end
                end

                ST_SPAWN: begin
                    req_reg      <= 1'b1;
                    cand_x_reg   <= SPAWN_XV;
                    cand_y_reg   <= '0;
                    cand_rot_reg <= '0;
                    act_reg      <= ACT_SPAWN;
                    state_reg    <= ST_CHECK;
                end

                ST_FALL: begin
                    if (q_any) begin
                        if (cand_reject) begin
                            if (pick == ACT_GRAV) begin
                                state_reg    <= ST_LOCK;
                                lock_cnt_reg <= '0;
                            end
                        end else begin
                            req_reg      <= 1'b1;
                            cand_x_reg   <= cx_next[4:0];
                            cand_y_reg   <= cy_next[4:0];
                            cand_rot_reg <= crot_next;
                            act_reg      <= pick;
                            state_reg    <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    if (chk.chk_ack) begin
                        req_reg     <= 1'b0;
                        collide_reg <= chk.chk_collide;
                        if (!chk.chk_collide) begin
                            x_reg      <= cand_x_reg;
                            y_reg      <= cand_y_reg;
                            rot_reg    <= cand_rot_reg;
                            // The spawn placement is not a player move.
                            accept_reg <= (act_reg != ACT_SPAWN);
                            state_reg  <= ST_FALL;
                        end else if (act_reg == ACT_SPAWN) begin
                            state_reg <= ST_OVER;
                        end else if (act_reg == ACT_GRAV) begin
                            state_reg    <= ST_LOCK;
                            lock_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_FALL;
                        end
                    end
                end

                ST_LOCK: begin
                    if (lock_done) begin
                        if (score_reg != SCORE_MAX) score_reg <= score_reg + 5'd1;
                        shape_reg <= next_shape(shape_reg);
                        x_reg     <= SPAWN_XV;
                        y_reg     <= '0;
                        rot_reg   <= '0;
                        state_reg <= ST_SPAWN;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end

                ST_OVER: ;

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign chk.chk_req  = req_reg;
    assign chk.cand_x   = cand_x_reg;
    assign chk.cand_y   = cand_y_reg;
    assign chk.cand_rot = cand_rot_reg;

    assign state       = state_reg;
    assign piece_x     = x_reg;
    assign piece_y     = y_reg;
    assign rot         = rot_reg;
    assign shape_id    = shape_reg;
    assign score       = score_reg;
    assign move_accept = accept_reg;
    assign have_action = (|pending) || (state_reg == ST_CHECK);
    assign lock_phase  = (state_reg == ST_LOCK);
    assign collide     = collide_reg;

endmodule

// File: tb/tb_tetris_piece_ctrl.sv
module tb_tetris_piece_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       left_final = 1'b0;
    logic       right_final = 1'b0;
    logic       rot_final = 1'b0;
    logic       tick_gravity = 1'b0;
    logic [3:0] state;
    logic [4:0] piece_x, piece_y;
    logic [2:0] rot, shape_id;
    logic [4:0] score;
    logic       move_accept, have_action, lock_phase, collide;

    int total = 0;
    int bad = 0;

    tetris_piece_ctrl_if chk_if ();

    tetris_piece_ctrl dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .start        (start),
        .left_final   (left_final),
        .right_final  (right_final),
        .rot_final    (rot_final),
        .tick_gravity (tick_gravity),
        .chk          (chk_if),
        .state        (state),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .rot          (rot),
        .shape_id     (shape_id),
        .score        (score),
        .move_accept  (move_accept),
        .have_action  (have_action),
        .lock_phase   (lock_phase),
        .collide      (collide)
    );

    always #5 clk = ~clk;

    initial begin
        chk_if.chk_ack = 1'b0;
        chk_if.chk_collide = 1'b0;
    end

    // One-cycle action pulse, driven between active edges.
    task automatic pulse(input logic l, input logic r, input logic t, input logic g);
        @(negedge clk);
        left_final = l; right_final = r; rot_final = t; tick_gravity = g;
        @(negedge clk);
        left_final = 0; right_final = 0; rot_final = 0; tick_gravity = 0;
    endtask

    // Checker model: wait (bounded) for a query, answer after 1 cycle.
    // Returns at the negedge following the ack edge.
    task automatic answer(input logic col, output bit seen,
                          output logic [4:0] cx, output logic [4:0] cy, output logic [2:0] cr);
        seen = 0; cx = 'x; cy = 'x; cr = 'x;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (chk_if.chk_req) seen = 1;
        end
        if (seen) begin
            cx = chk_if.cand_x; cy = chk_if.cand_y; cr = chk_if.cand_rot;
            @(negedge clk);
            chk_if.chk_ack = 1'b1; chk_if.chk_collide = col;
            @(negedge clk);
            chk_if.chk_ack = 1'b0; chk_if.chk_collide = 1'b0;
            $display("query x=%0d y=%0d rot=%0d collide=%0d", cx, cy, cr, col);
        end else begin
            $display("query not raised");
        end
    endtask

    task automatic test_reset;
        bit seen; logic [4:0] cx, cy; logic [2:0] cr;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (piece_x !== 5'd4 || piece_y !== 5'd0 || rot !== 3'd0) begin bad++; $display("FAIL reset_pos got=%0d,%0d,%0d want=4,0,0", piece_x, piece_y, rot); end
        total++; if (shape_id !== 3'd1 || score !== 5'd0) begin bad++; $display("FAIL reset_shape_score got=%0d,%0d want=1,0", shape_id, score); end
        total++; if (chk_if.chk_req !== 1'b0 || move_accept !== 1'b0 || have_action !== 1'b0 || lock_phase !== 1'b0 || collide !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b%b%b want=00000", chk_if.chk_req, move_accept, have_action, lock_phase, collide); end
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (state !== 4'd1) begin bad++; $display("FAIL start_spawn got=%0d want=1", state); end
        answer(1'b0, seen, cx, cy, cr);
        total++; if (!seen || cx !== 5'd4 || cy !== 5'd0 || cr !== 3'd0) begin bad++; $display("FAIL spawn_query got=%0d/%0d,%0d,%0d want=1/4,0,0", seen, cx, cy, cr); end
        total++; if (state !== 4'd2 || move_accept !== 1'b0) begin bad++; $display("FAIL spawn_fall got=%0d,%0d want=2,0", state, move_accept); end
        total++; if (piece_x !== 5'd4 || piece_y !== 5'd0 || rot !== 3'd0) begin bad++; $display("FAIL spawn_pos got=%0d,%0d,%0d want=4,0,0", piece_x, piece_y, rot); end
    endtask

    task automatic test_gravity;
        bit seen; logic [4:0] cx, cy; logic [2:0] cr;
        int accepts = 0;
        for (int i = 0; i < 6; i++) begin
            pulse(0, 0, 0, 1);
            answer(1'b0, seen, cx, cy, cr);
            total++; if (!seen || cy !== 5'(i + 1) || cx !== 5'd4) begin bad++; $display("FAIL grav_cand got=%0d/%0d,%0d want=1/4,%0d", seen, cx, cy, i + 1); end
            if (move_accept === 1'b1) accepts++;
            total++; if (chk_if.chk_req !== 1'b0) begin bad++; $display("FAIL grav_req_drop got=%0d want=0", chk_if.chk_req); end
        end
        total++; if (piece_y !== 5'd6) begin bad++; $display("FAIL grav_y got=%0d want=6", piece_y); end
        total++; if (accepts != 6) begin bad++; $display("FAIL grav_accepts got=%0d want=6", accepts); end
    endtask

    task automatic test_edges;
        bit seen; logic [4:0] cx, cy; logic [2:0] cr;
        bit saw;
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, 0, 0);
            answer(1'b0, seen, cx, cy, cr);
            total++; if (!seen || cx !== 5'(3 - i)) begin bad++; $display("FAIL left_cand got=%0d/%0d want=1/%0d", seen, cx, 3 - i); end
        end
        total++; if (piece_x !== 5'd0) begin bad++; $display("FAIL left_x0 got=%0d want=0", piece_x); end
        pulse(1, 0, 0, 0);
        saw = 0;
        repeat (4) begin @(negedge clk); if (chk_if.chk_req || move_accept) saw = 1; end
        total++; if (saw !== 1'b0 || piece_x !== 5'd0) begin bad++; $display("FAIL left_reject got=%0d,x=%0d want=0,x=0", saw, piece_x); end
        total++; if (have_action !== 1'b0 || state !== 4'd2) begin bad++; $display("FAIL left_reject_idle got=%0d,%0d want=0,2", have_action, state); end
        $display("reject left at x=0");
        for (int i = 0; i < 9; i++) begin
            pulse(0, 1, 0, 0);
            answer(1'b0, seen, cx, cy, cr);
            total++; if (!seen || cx !== 5'(i + 1)) begin bad++; $display("FAIL right_cand got=%0d/%0d want=1/%0d", seen, cx, i + 1); end
        end
        pulse(0, 1, 0, 0);
        saw = 0;
        repeat (4) begin @(negedge clk); if (chk_if.chk_req || move_accept) saw = 1; end
        total++; if (saw !== 1'b0 || piece_x !== 5'd9) begin bad++; $display("FAIL right_reject got=%0d,x=%0d want=0,x=9", saw, piece_x); end
        $display("reject right at x=9");
    endtask

    task automatic test_back_to_back;
        bit seen; logic [4:0] cx, cy; logic [2:0] cr;
        pulse(1, 0, 1, 1);
        total++; if (have_action !== 1'b1) begin bad++; $display("FAIL b2b_have got=%0d want=1", have_action); end
        answer(1'b0, seen, cx, cy, cr);
        total++; if (!seen || cx !== 5'd8 || cy !== 5'd6 || cr !== 3'd0) begin bad++; $display("FAIL b2b_first got=%0d,%0d,%0d want=8,6,0", cx, cy, cr); end
        answer(1'b0, seen, cx, cy, cr);
        total++; if (!seen || cx !== 5'd8 || cy !== 5'd6 || cr !== 3'd1) begin bad++; $display("FAIL b2b_second got=%0d,%0d,%0d want=8,6,1", cx, cy, cr); end
        answer(1'b0, seen, cx, cy, cr);
        total++; if (!seen || cx !== 5'd8 || cy !== 5'd7 || cr !== 3'd1) begin bad++; $display("FAIL b2b_third got=%0d,%0d,%0d want=8,7,1", cx, cy, cr); end
        total++; if (piece_x !== 5'd8 || piece_y !== 5'd7 || rot !== 3'd1) begin bad++; $display("FAIL b2b_pos got=%0d,%0d,%0d want=8,7,1", piece_x, piece_y, rot); end
    endtask

    task automatic test_lock;
        bit seen; logic [4:0] cx, cy; logic [2:0] cr;
        int cnt;
        for (int k = 1; k <= 32; k++) begin
            pulse(0, 0, 0, 1);
            answer(1'b1, seen, cx, cy, cr);
            total++; if (!seen || state !== 4'd4 || collide !== 1'b1) begin bad++; $display("FAIL lock_enter k=%0d got=%0d,%0d want=4,1", k, state, collide); end
            cnt = 0;
            while (lock_phase === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
            total++; if (cnt != 16) begin bad++; $display("FAIL lock_len k=%0d got=%0d want=16", k, cnt); end
            total++; if (state !== 4'd1 || piece_x !== 5'd4 || piece_y !== 5'd0 || rot !== 3'd0) begin bad++; $display("FAIL respawn k=%0d got=%0d,%0d,%0d,%0d want=1,4,0,0", k, state, piece_x, piece_y, rot); end
            total++; if (score !== 5'((k > 31) ? 31 : k) || shape_id !== 3'((k % 7) + 1)) begin bad++; $display("FAIL lock_score k=%0d got=%0d,%0d want=%0d,%0d", k, score, shape_id, (k > 31) ? 31 : k, (k % 7) + 1); end
            $display("lock %0d score=%0d shape=%0d", k, score, shape_id);
            answer(1'b0, seen, cx, cy, cr);
            total++; if (!seen || state !== 4'd2) begin bad++; $display("FAIL respawn_fall k=%0d got=%0d want=2", k, state); end
        end
    endtask

    task automatic test_over_and_reset;
        bit seen; logic [4:0] cx, cy; logic [2:0] cr;
        bit saw;
        pulse(0, 0, 0, 1);
        answer(1'b1, seen, cx, cy, cr);
        repeat (16) @(negedge clk);
        answer(1'b1, seen, cx, cy, cr);
        total++; if (!seen || state !== 4'd5) begin bad++; $display("FAIL over_enter got=%0d want=5", state); end
        pulse(1, 0, 0, 1);
        saw = 0;
        repeat (4) begin @(negedge clk); if (chk_if.chk_req || state !== 4'd5) saw = 1; end
        total++; if (saw !== 1'b0 || have_action !== 1'b0 || score !== 5'd31) begin bad++; $display("FAIL over_hold got=%0d,%0d,%0d want=0,0,31", saw, have_action, score); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        total++; if (state !== 4'd0 || score !== 5'd0 || shape_id !== 3'd1) begin bad++; $display("FAIL over_reset got=%0d,%0d,%0d want=0,0,1", state, score, shape_id); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        answer(1'b0, seen, cx, cy, cr);
        pulse(1, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (chk_if.chk_req) seen = 1; else @(negedge clk);
        end
        total++; if (!seen || state !== 4'd3) begin bad++; $display("FAIL mid_check got=%0d,%0d want=1,3", seen, state); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (chk_if.chk_req !== 1'b0 || state !== 4'd0) begin bad++; $display("FAIL mid_reset got=%0d,%0d want=0,0", chk_if.chk_req, state); end
        $display("reset during check");
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_edges();
        test_back_to_back();
        test_lock();
        test_over_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
